// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: default widths,
// controller state encoding and the hard-wired zero register.
package pipe_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // $0 reads as zero and is never a real dependency.
    localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the MIPS datapath (master) and the hazard controller (slave):
// register specifiers and write enables in, stall/flush controls and debug counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);

    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic [REG_W-1:0] EX_Dst;
    logic             EX_WrEn;
    logic [REG_W-1:0] MEM_Dst;
    logic             MEM_WrEn;
    logic [REG_W-1:0] WB_Dst;
    logic             WB_WrEn;
    logic             MEM_Redirect;

    logic             PC_Ld;
    logic             IF_ID_Ld;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic [1:0]       State;
    logic [CNT_W-1:0] CycleCnt;
    logic [CNT_W-1:0] RetireCnt;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
        output EX_Dst, EX_WrEn, MEM_Dst, MEM_WrEn, WB_Dst, WB_WrEn,
        output MEM_Redirect,
        input  PC_Ld, IF_ID_Ld, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
        input  State, CycleCnt, RetireCnt, StallCnt, FlushCnt
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
        input  EX_Dst, EX_WrEn, MEM_Dst, MEM_WrEn, WB_Dst, WB_WrEn,
        input  MEM_Redirect,
        output PC_Ld, IF_ID_Ld, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
        output State, CycleCnt, RetireCnt, StallCnt, FlushCnt
    );

endinterface

// File: rtl/perf_counter.sv
// Free-running debug event counter with synchronous clear; wraps modulo 2^CNT_W.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Inc,
    output logic [CNT_W-1:0] Count
);

    logic [CNT_W-1:0] countReg;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            countReg <= '0;
        end else if (Inc) begin
            countReg <= countReg + CNT_W'(1);
        end
    end

    assign Count = countReg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline without forwarding, where
// branches and jumps resolve in MEM; also keeps cycle/retire/stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = pipe_pkg::CNT_W,
    parameter int REG_W = pipe_pkg::REG_W
) (
    input  logic                  Clk,
    input  logic                  Rst,
    pipeline_hazard_ctrl_if.slave bus
);

    import pipe_pkg::state_t;
    import pipe_pkg::ST_RUN;
    import pipe_pkg::ST_STALL;
    import pipe_pkg::ST_FLUSH;
    import pipe_pkg::ZERO_REG;

    localparam int N_WR  = 3;   // writers checked against ID: EX, MEM, WB
    localparam int N_CNT = 4;   // cycle, retire, stall, flush

    logic   vIfIdReg;
    logic   vIdExReg;
    logic   vExMemReg;
    logic   vMemWbReg;
    state_t stateReg;

    logic [REG_W-1:0] idRs;
    logic [REG_W-1:0] idRt;
    logic             rsLive;
    logic             rtLive;
    logic [REG_W-1:0] wrDst [N_WR];
    logic [N_WR-1:0]  wrLive;
    logic [N_WR-1:0]  srcHit;
    logic             haz;
    logic             redirect;
    logic             stall;

    assign idRs   = bus.ID_Rs;
    assign idRt   = bus.ID_Rt;
    assign rsLive = vIfIdReg & bus.ID_UsesRs & (idRs != REG_W'(ZERO_REG));
    assign rtLive = vIfIdReg & bus.ID_UsesRt & (idRt != REG_W'(ZERO_REG));

    // WB counts as a writer: the register file only updates at the edge,
    // so ID reading in the same cycle still sees the stale value.
    assign wrDst[0] = bus.EX_Dst;
    assign wrDst[1] = bus.MEM_Dst;
    assign wrDst[2] = bus.WB_Dst;
    assign wrLive   = {vMemWbReg & bus.WB_WrEn,
                       vExMemReg & bus.MEM_WrEn,
                       vIdExReg  & bus.EX_WrEn};

    genvar gi;
    generate
        for (gi = 0; gi < N_WR; gi++) begin : g_wr
            assign srcHit[gi] = wrLive[gi] &
                                ((rsLive & (idRs == wrDst[gi])) |
                                 (rtLive & (idRt == wrDst[gi])));
        end
    endgenerate

    assign haz      = |srcHit;
    assign redirect = bus.MEM_Redirect & vExMemReg;
    assign stall    = haz & ~redirect;

    always_comb begin
        bus.PC_Ld        = 1'b1;
        bus.IF_ID_Ld     = 1'b1;
        bus.IF_ID_Flush  = 1'b0;
        bus.ID_EX_Flush  = 1'b0;
        bus.EX_MEM_Flush = 1'b0;
        if (!Rst) begin
            if (redirect) begin
                bus.IF_ID_Flush  = 1'b1;
                bus.ID_EX_Flush  = 1'b1;
                bus.EX_MEM_Flush = 1'b1;
            end else if (stall) begin
                bus.PC_Ld       = 1'b0;
                bus.IF_ID_Ld    = 1'b0;
                bus.ID_EX_Flush = 1'b1;
            end
        end
    end

    // The redirecting instruction sits in MEM and still retires; only the
    // younger EX, ID and IF instructions are squashed.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vIfIdReg  <= 1'b0;
            vIdExReg  <= 1'b0;
            vExMemReg <= 1'b0;
            vMemWbReg <= 1'b0;
            stateReg  <= ST_RUN;
        end else begin
            vMemWbReg <= vExMemReg;
            vExMemReg <= vIdExReg & ~redirect;
            vIdExReg  <= vIfIdReg & ~redirect & ~stall;
            if (redirect) begin
                vIfIdReg <= 1'b0;
            end else if (!stall) begin
                vIfIdReg <= 1'b1;
            end
            if (redirect) begin
                stateReg <= ST_FLUSH;
            end else if (stall) begin
                stateReg <= ST_STALL;
            end else begin
                stateReg <= ST_RUN;
            end
        end
    end

    assign bus.State = stateReg;

    logic [N_CNT-1:0] cntInc;
    logic [CNT_W-1:0] cntVal [N_CNT];

    assign cntInc = {redirect, stall, vMemWbReg, 1'b1};

    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
            perf_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .Clk  (Clk),
                .Clr  (Rst),
                .Inc  (cntInc[gi]),
                .Count(cntVal[gi])
            );
        end
    endgenerate

    assign bus.CycleCnt  = cntVal[0];
    assign bus.RetireCnt = cntVal[1];
    assign bus.StallCnt  = cntVal[2];
    assign bus.FlushCnt  = cntVal[3];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: an instruction-level pipeline model feeds the
// controller and predicts its controls, state and counters.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;
    localparam int REG_W = 5;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .CNT_W(CNT_W),
        .REG_W(REG_W)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    typedef struct {
        bit       valid;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       usesRs;
        bit       usesRt;
        bit [4:0] dst;
        bit       wrEn;
        bit       redirect;
    } instr_t;

    typedef struct {
        logic             pcLd;
        logic             ifIdLd;
        logic             ifIdFl;
        logic             idExFl;
        logic             exMemFl;
        logic [1:0]       state;
        logic [CNT_W-1:0] cyc;
        logic [CNT_W-1:0] ret;
        logic [CNT_W-1:0] stl;
        logic [CNT_W-1:0] flu;
    } snap_t;

    int compared   = 0;
    int mismatched = 0;

    // Program stream and the instruction occupying each pipeline register.
    instr_t prog[$];
    instr_t ifid, idex, exmem, memwb;
    int unsigned mCycle, mRetire, mStall, mFlush;
    int mState;
    snap_t obs, expv;
    int obsStalls, obsFlushes;

    function automatic instr_t bubble();
        instr_t i;
        i.valid = 0; i.rs = 0; i.rt = 0; i.usesRs = 0; i.usesRt = 0;
        i.dst = 0; i.wrEn = 0; i.redirect = 0;
        return i;
    endfunction

    function automatic instr_t mkNop();
        instr_t i = bubble();
        i.valid = 1;
        return i;
    endfunction

    function automatic instr_t mkAlu(int dst, int rs, int rt);
        instr_t i = mkNop();
        i.rs = 5'(rs); i.rt = 5'(rt); i.usesRs = 1; i.usesRt = 1;
        i.dst = 5'(dst); i.wrEn = 1;
        return i;
    endfunction

    function automatic instr_t mkBranch();
        instr_t i = mkNop();
        i.redirect = 1;
        return i;
    endfunction

    function automatic instr_t randInstr();
        instr_t i = mkNop();
        i.rs       = 5'($urandom_range(0, 7));
        i.rt       = 5'($urandom_range(0, 7));
        i.usesRs   = 1'($urandom);
        i.usesRt   = 1'($urandom);
        i.dst      = 5'($urandom_range(0, 7));
        i.wrEn     = ($urandom_range(0, 3) != 0);
        i.redirect = ($urandom_range(0, 9) == 0);
        return i;
    endfunction

    // An older in-flight instruction still owes a write of register r.
    function automatic bit owed(bit uses, bit [4:0] r);
        if (!uses || r == 5'd0) return 0;
        if (idex.valid  && idex.wrEn  && idex.dst  == r) return 1;
        if (exmem.valid && exmem.wrEn && exmem.dst == r) return 1;
        if (memwb.valid && memwb.wrEn && memwb.dst == r) return 1;
        return 0;
    endfunction

    // One clock: drive the datapath view (junk for empty slots), predict,
    // sample at the falling edge, then advance the model at the rising edge.
    task automatic step(input bit rstVal);
        bit redir, haz, stallNow;
        Rst = rstVal;
        bus.ID_Rs        = ifid.valid  ? ifid.rs     : 5'($urandom);
        bus.ID_Rt        = ifid.valid  ? ifid.rt     : 5'($urandom);
        bus.ID_UsesRs    = ifid.valid  ? ifid.usesRs : 1'($urandom);
        bus.ID_UsesRt    = ifid.valid  ? ifid.usesRt : 1'($urandom);
        bus.EX_Dst       = idex.valid  ? idex.dst    : 5'($urandom);
        bus.EX_WrEn      = idex.valid  ? idex.wrEn   : 1'($urandom);
        bus.MEM_Dst      = exmem.valid ? exmem.dst   : 5'($urandom);
        bus.MEM_WrEn     = exmem.valid ? exmem.wrEn  : 1'($urandom);
        bus.MEM_Redirect = exmem.valid ? exmem.redirect : 1'($urandom);
        bus.WB_Dst       = memwb.valid ? memwb.dst   : 5'($urandom);
        bus.WB_WrEn      = memwb.valid ? memwb.wrEn  : 1'($urandom);

        redir    = exmem.valid && exmem.redirect;
        haz      = ifid.valid && (owed(ifid.usesRs, ifid.rs) || owed(ifid.usesRt, ifid.rt));
        stallNow = haz && !redir;

        expv.pcLd    = rstVal || !stallNow;
        expv.ifIdLd  = rstVal || !stallNow;
        expv.ifIdFl  = !rstVal && redir;
        expv.idExFl  = !rstVal && (redir || stallNow);
        expv.exMemFl = !rstVal && redir;
        expv.state   = 2'(mState);
        expv.cyc     = mCycle;
        expv.ret     = mRetire;
        expv.stl     = mStall;
        expv.flu     = mFlush;

        @(negedge Clk);
        obs.pcLd    = bus.PC_Ld;
        obs.ifIdLd  = bus.IF_ID_Ld;
        obs.ifIdFl  = bus.IF_ID_Flush;
        obs.idExFl  = bus.ID_EX_Flush;
        obs.exMemFl = bus.EX_MEM_Flush;
        obs.state   = bus.State;
        obs.cyc     = bus.CycleCnt;
        obs.ret     = bus.RetireCnt;
        obs.stl     = bus.StallCnt;
        obs.flu     = bus.FlushCnt;
        if (obs.pcLd === 1'b0 && obs.idExFl === 1'b1) obsStalls++;
        if (obs.pcLd === 1'b1 && obs.ifIdFl === 1'b1 && obs.idExFl === 1'b1 && obs.exMemFl === 1'b1) obsFlushes++;

        @(posedge Clk);
        if (rstVal) begin
            ifid = bubble(); idex = bubble(); exmem = bubble(); memwb = bubble();
            mCycle = 0; mRetire = 0; mStall = 0; mFlush = 0; mState = 0;
        end else begin
            if (memwb.valid) mRetire++;
            mCycle++;
            if (stallNow) mStall++;
            if (redir) mFlush++;
            mState = redir ? 2 : (stallNow ? 1 : 0);
            memwb = exmem;
            exmem = redir ? bubble() : idex;
            idex  = (redir || stallNow) ? bubble() : ifid;
            if (redir) begin
                ifid = bubble();
            end else if (!stallNow) begin
                if (prog.size() > 0) ifid = prog.pop_front();
                else ifid = mkNop();
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic do_reset();
        step(1'b1);
        step(1'b1);
        prog.delete();
        obsStalls = 0;
        obsFlushes = 0;
    endtask

    task automatic test_reset();
        step(1'b1);
        compared++; if (obs.pcLd !== 1'b1) begin mismatched++; $display("FAIL reset_pcld: got %b want 1", obs.pcLd); end
        compared++; if (obs.ifIdLd !== 1'b1) begin mismatched++; $display("FAIL reset_ifidld: got %b want 1", obs.ifIdLd); end
        compared++; if ({obs.ifIdFl, obs.idExFl, obs.exMemFl} !== 3'b000) begin mismatched++; $display("FAIL reset_flush: got %b want 000", {obs.ifIdFl, obs.idExFl, obs.exMemFl}); end
        do_reset();
        step(1'b0);
        compared++; if (obs.cyc !== 0) begin mismatched++; $display("FAIL reset_cyc: got %0d want 0", obs.cyc); end
        compared++; if (obs.ret !== 0) begin mismatched++; $display("FAIL reset_ret: got %0d want 0", obs.ret); end
        compared++; if (obs.stl !== 0) begin mismatched++; $display("FAIL reset_stall: got %0d want 0", obs.stl); end
        compared++; if (obs.flu !== 0) begin mismatched++; $display("FAIL reset_flushcnt: got %0d want 0", obs.flu); end
        compared++; if (obs.state !== 2'd0) begin mismatched++; $display("FAIL reset_state: got %0d want 0", obs.state); end
        compared++; if (obs.pcLd !== 1'b1) begin mismatched++; $display("FAIL reset_run_pcld: got %b want 1", obs.pcLd); end
        $display("test_reset done: cyc=%0d state=%0d", obs.cyc, obs.state);
    endtask

    task automatic test_independent();
        do_reset();
        for (int i = 0; i < 10; i++) prog.push_back(mkAlu(8 + i, $urandom_range(1, 7), $urandom_range(1, 7)));
        run(14);
        step(1'b0);
        compared++; if (obs.ret !== 10) begin mismatched++; $display("FAIL indep_retire: got %0d want 10", obs.ret); end
        compared++; if (obs.stl !== 0) begin mismatched++; $display("FAIL indep_stallcnt: got %0d want 0", obs.stl); end
        compared++; if (obs.cyc !== 14) begin mismatched++; $display("FAIL indep_cycles: got %0d want 14", obs.cyc); end
        compared++; if (obsStalls !== 0) begin mismatched++; $display("FAIL indep_stall_cycles: got %0d want 0", obsStalls); end
        compared++; if (obsFlushes !== 0) begin mismatched++; $display("FAIL indep_flush_cycles: got %0d want 0", obsFlushes); end
        $display("test_independent done: retire=%0d stalls=%0d", obs.ret, obs.stl);
    endtask

    task automatic test_raw_distance();
        int dists[4] = '{1, 2, 3, 4};
        int want[4]  = '{3, 2, 1, 0};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            prog.push_back(mkAlu(3, 1, 2));
            for (int f = 0; f < dists[k] - 1; f++) prog.push_back(mkAlu(9 + f, 20, 21));
            prog.push_back(mkAlu(4, 3, 5));
            run(16);
            step(1'b0);
            compared++; if (obs.stl !== CNT_W'(want[k])) begin mismatched++; $display("FAIL raw_d%0d_stallcnt: got %0d want %0d", dists[k], obs.stl, want[k]); end
            compared++; if (obsStalls !== want[k]) begin mismatched++; $display("FAIL raw_d%0d_stall_cycles: got %0d want %0d", dists[k], obsStalls, want[k]); end
            $display("test_raw_distance d=%0d: stallcnt=%0d stall_cycles=%0d", dists[k], obs.stl, obsStalls);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        prog.push_back(mkAlu(0, 1, 2));
        prog.push_back(mkAlu(4, 0, 0));
        run(10);
        step(1'b0);
        compared++; if (obs.stl !== 0) begin mismatched++; $display("FAIL zero_stallcnt: got %0d want 0", obs.stl); end
        compared++; if (obsStalls !== 0) begin mismatched++; $display("FAIL zero_stall_cycles: got %0d want 0", obsStalls); end
        $display("test_zero_reg done: stallcnt=%0d", obs.stl);
    endtask

    task automatic test_branch();
        do_reset();
        prog.push_back(mkAlu(8, 20, 21));
        prog.push_back(mkBranch());
        prog.push_back(mkAlu(9, 20, 21));
        prog.push_back(mkAlu(10, 20, 21));
        prog.push_back(mkAlu(11, 20, 21));
        prog.push_back(mkAlu(12, 20, 21));
        run(9);
        step(1'b0);
        compared++; if (obs.ret !== 2) begin mismatched++; $display("FAIL branch_retire9: got %0d want 2", obs.ret); end
        compared++; if (obs.flu !== 1) begin mismatched++; $display("FAIL branch_flushcnt: got %0d want 1", obs.flu); end
        compared++; if (obsFlushes !== 1) begin mismatched++; $display("FAIL branch_flush_cycles: got %0d want 1", obsFlushes); end
        step(1'b0);
        step(1'b0);
        compared++; if (obs.ret !== 4) begin mismatched++; $display("FAIL branch_retire11: got %0d want 4", obs.ret); end
        compared++; if (obs.stl !== 0) begin mismatched++; $display("FAIL branch_stallcnt: got %0d want 0", obs.stl); end
        $display("test_branch done: retire=%0d flushcnt=%0d", obs.ret, obs.flu);
    endtask

    task automatic test_redirect_in_stall();
        do_reset();
        prog.push_back(mkAlu(5, 20, 21));
        prog.push_back(mkBranch());
        prog.push_back(mkAlu(6, 5, 21));
        prog.push_back(mkAlu(7, 20, 21));
        run(5);
        step(1'b0);
        compared++; if (obs.state !== 2'd2) begin mismatched++; $display("FAIL redir_stall_state: got %0d want 2", obs.state); end
        compared++; if (obs.stl !== 1) begin mismatched++; $display("FAIL redir_stall_stallcnt: got %0d want 1", obs.stl); end
        compared++; if (obs.flu !== 1) begin mismatched++; $display("FAIL redir_stall_flushcnt: got %0d want 1", obs.flu); end
        compared++; if (obs.pcLd !== 1'b1) begin mismatched++; $display("FAIL redir_stall_after_pcld: got %b want 1", obs.pcLd); end
        compared++; if (obsFlushes !== 1) begin mismatched++; $display("FAIL redir_stall_flush_cycles: got %0d want 1", obsFlushes); end
        $display("test_redirect_in_stall done: state=%0d stalls=%0d flushes=%0d", obs.state, obs.stl, obs.flu);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        prog.push_back(mkAlu(3, 1, 2));
        prog.push_back(mkAlu(4, 3, 5));
        run(4);
        compared++; if (obsStalls !== 2) begin mismatched++; $display("FAIL midrst_pre_stalls: got %0d want 2", obsStalls); end
        step(1'b1);
        compared++; if (obs.state !== 2'd1) begin mismatched++; $display("FAIL midrst_state_before: got %0d want 1", obs.state); end
        compared++; if (obs.pcLd !== 1'b1 || obs.idExFl !== 1'b0) begin mismatched++; $display("FAIL midrst_in_reset_ctl: got pcld=%b idex=%b want 1/0", obs.pcLd, obs.idExFl); end
        step(1'b0);
        compared++; if (obs.cyc !== 0 || obs.ret !== 0 || obs.stl !== 0 || obs.flu !== 0) begin mismatched++; $display("FAIL midrst_counters: got %0d/%0d/%0d/%0d want 0/0/0/0", obs.cyc, obs.ret, obs.stl, obs.flu); end
        compared++; if (obs.state !== 2'd0) begin mismatched++; $display("FAIL midrst_state: got %0d want 0", obs.state); end
        compared++; if (obs.pcLd !== 1'b1 || obs.idExFl !== 1'b0) begin mismatched++; $display("FAIL midrst_after_ctl: got pcld=%b idex=%b want 1/0", obs.pcLd, obs.idExFl); end
        $display("test_reset_mid_stall done: state=%0d cyc=%0d", obs.state, obs.cyc);
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            while (prog.size() < 4) prog.push_back(randInstr());
            step((c % 137) == 136);
            compared++; if (obs.pcLd    !== expv.pcLd)    begin mismatched++; bad++; $display("FAIL rnd_pcld c=%0d: got %b want %b", c, obs.pcLd, expv.pcLd); end
            compared++; if (obs.ifIdLd  !== expv.ifIdLd)  begin mismatched++; bad++; $display("FAIL rnd_ifidld c=%0d: got %b want %b", c, obs.ifIdLd, expv.ifIdLd); end
            compared++; if (obs.ifIdFl  !== expv.ifIdFl)  begin mismatched++; bad++; $display("FAIL rnd_ifidfl c=%0d: got %b want %b", c, obs.ifIdFl, expv.ifIdFl); end
            compared++; if (obs.idExFl  !== expv.idExFl)  begin mismatched++; bad++; $display("FAIL rnd_idexfl c=%0d: got %b want %b", c, obs.idExFl, expv.idExFl); end
            compared++; if (obs.exMemFl !== expv.exMemFl) begin mismatched++; bad++; $display("FAIL rnd_exmemfl c=%0d: got %b want %b", c, obs.exMemFl, expv.exMemFl); end
            compared++; if (obs.state   !== expv.state)   begin mismatched++; bad++; $display("FAIL rnd_state c=%0d: got %0d want %0d", c, obs.state, expv.state); end
            compared++; if (obs.cyc     !== expv.cyc)     begin mismatched++; bad++; $display("FAIL rnd_cycle c=%0d: got %0d want %0d", c, obs.cyc, expv.cyc); end
            compared++; if (obs.ret     !== expv.ret)     begin mismatched++; bad++; $display("FAIL rnd_retire c=%0d: got %0d want %0d", c, obs.ret, expv.ret); end
            compared++; if (obs.stl     !== expv.stl)     begin mismatched++; bad++; $display("FAIL rnd_stallcnt c=%0d: got %0d want %0d", c, obs.stl, expv.stl); end
            compared++; if (obs.flu     !== expv.flu)     begin mismatched++; bad++; $display("FAIL rnd_flushcnt c=%0d: got %0d want %0d", c, obs.flu, expv.flu); end
        end
        $display("test_random done: cycles=400 retire=%0d stalls=%0d flushes=%0d bad=%0d", mRetire, mStall, mFlush, bad);
    endtask

    initial begin
        ifid = bubble(); idex = bubble(); exmem = bubble(); memwb = bubble();
        mCycle = 0; mRetire = 0; mStall = 0; mFlush = 0; mState = 0;
        obsStalls = 0; obsFlushes = 0;
        test_reset();
        test_independent();
        test_raw_distance();
        test_zero_reg();
        test_branch();
        test_redirect_in_stall();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
